axi_wr_arbiter: RTL and testbench
=================================

AXI_WR_ARBITER -- requirements
Module: axi_wr_arbiter

Interface
REQ-001 SHALL have parameter MASTER_NUM, default 2, number of upstream masters (>=2).
REQ-002 SHALL have parameter ID_WIDTH, default 4, master-side ID width; slave-side ID width = ID_WIDTH+IW, IW = $clog2(MASTER_NUM).
REQ-003 SHALL have parameter ADDR_WIDTH, default 64, address width.
REQ-004 SHALL have parameter DATA_WIDTH, default 64, data width; strobe width DATA_WIDTH/8.
REQ-005 SHALL have parameter FIFO_DEPTH, default 4, W-order FIFO entries (power of two).
REQ-006 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-007 rstn  in  1  asynchronous active-low reset.
REQ-008 m_aw_valid / m_aw_ready  in / out  [MASTER_NUM]  per-master AW handshake.
REQ-009 m_aw_id  in  [MASTER_NUM][ID_WIDTH]  per-master AW ID.
REQ-010 m_aw_addr  in  [MASTER_NUM][ADDR_WIDTH]  per-master AW address.
REQ-011 m_w_valid / m_w_ready / m_w_last  in / out / in  [MASTER_NUM]  per-master W handshake and last beat.
REQ-012 m_w_data  in  [MASTER_NUM][DATA_WIDTH]  per-master write data.
REQ-013 m_w_strb  in  [MASTER_NUM][DATA_WIDTH/8]  per-master write strobes.
REQ-014 m_b_valid / m_b_ready  out / in  [MASTER_NUM]  per-master B handshake.
REQ-015 m_b_id  out  [ID_WIDTH]  shared B ID, low bits of s_b_id.
REQ-016 m_b_resp  out  2  shared B response.
REQ-017 s_aw_valid / s_aw_ready  out / in  1  slave AW handshake.
REQ-018 s_aw_id  out  ID_WIDTH+IW  {grant index, master ID}.
REQ-019 s_aw_addr  out  ADDR_WIDTH  slave AW address.
REQ-020 s_w_valid / s_w_ready / s_w_last  out / in / out  1  slave W handshake and last beat.
REQ-021 s_w_data  out  DATA_WIDTH; s_w_strb  out  DATA_WIDTH/8.
REQ-022 s_b_valid / s_b_ready  in / out  1  slave B handshake.
REQ-023 s_b_id  in  ID_WIDTH+IW; s_b_resp  in  2.

Function
REQ-024 AW stage SHALL be a one-entry register: loads when empty or when s_aw_valid&&s_aw_ready; s_aw_* driven from register; AW latency exactly 1 cycle.
REQ-025 Arbitration SHALL be round-robin: search starts at pointer rr; lowest index >= rr (wrapping) with m_aw_valid wins; only winner sees m_aw_ready=1.
REQ-026 On each AW load, rr SHALL become (winner+1) mod MASTER_NUM; rr unchanged when no load.
REQ-027 Every AW load SHALL push winner index into W-order FIFO; if FIFO full, all m_aw_ready=0 even if a pop occurs that cycle.
REQ-028 W path SHALL route from master at FIFO head: s_w_* = m_w_*[head], m_w_ready[head] = s_w_ready, all other m_w_ready=0.
REQ-029 FIFO empty SHALL force s_w_valid=0 and all m_w_ready=0; W data accompanying its AW in same cycle forwarded no earlier than the next cycle.
REQ-030 FIFO SHALL pop on s_w_valid&&s_w_ready&&s_w_last; beats without last do not pop.
REQ-031 B path SHALL be combinational: idx = s_b_id[top IW bits]; m_b_valid[idx]=s_b_valid, s_b_ready=m_b_ready[idx], others 0.
REQ-032 idx >= MASTER_NUM SHALL set s_b_ready=1 and assert no m_b_valid (response discarded).
REQ-033 Holding AW register SHALL keep s_aw_* stable while s_aw_valid&&!s_aw_ready.

Reset
REQ-034 rstn low SHALL immediately force s_aw_valid=0, s_w_valid=0, all m_aw_ready=0, FIFO empty, rr=0, AW register empty; mid-burst reset discards in-flight state.
REQ-035 First AW acceptance SHALL occur no earlier than the first rising edge after rstn deasserts.

Verification
REQ-036 Masters 0,1 assert AW together, s_aw_ready=1 -> grants 0 then 1, s_aw_id = {0,id0} then {1,id1}, one per cycle.
REQ-037 Master 1 AW, then master 0 AW, each 4-beat W issued concurrently -> s_w carries master 1's 4 beats then master 0's 4 beats.
REQ-038 FIFO_DEPTH=4, s_w_ready=0, five AWs offered -> four accepted, fifth held with m_aw_ready=0 until a WLAST pop.
REQ-039 s_b_id = {1,4'h3}, s_b_resp=2'b10 -> m_b_valid[1]=1, m_b_id=4'h3, m_b_resp=2'b10; s_b_ready tracks m_b_ready[1].
REQ-040 MASTER_NUM=3, s_b_id top bits = 3 -> s_b_ready=1, no m_b_valid; rstn pulsed mid-W-burst -> s_w_valid=0 same cycle, FIFO empty, next grant from master 0.

Source files
------------

// File: rtl/axi_wr_arbiter.sv
// axi_wr_arbiter: round-robin N:1 AXI write arbiter with W-order FIFO and B demux
// Ports:
//   clk, rstn                        rising-edge clock, asynchronous active-low reset
//   m_aw_valid/ready/id/addr         per-master AW channel
//   m_w_valid/ready/last/data/strb   per-master W channel
//   m_b_valid/ready, m_b_id/resp     per-master B handshake, shared B id/resp
//   s_aw_valid/ready/id/addr         slave AW channel, s_aw_id = {grant index, master id}
//   s_w_valid/ready/last/data/strb   slave W channel
//   s_b_valid/ready/id/resp          slave B channel, top IW id bits select the master
module axi_wr_arbiter #(
    parameter int MASTER_NUM = 2,
    parameter int ID_WIDTH   = 4,
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64,
    parameter int FIFO_DEPTH = 4,
    localparam int IW = $clog2(MASTER_NUM),
    localparam int SW = DATA_WIDTH / 8
) (
    input  logic                                 clk,
    input  logic                                 rstn,
    input  logic [MASTER_NUM-1:0]                m_aw_valid,
    output logic [MASTER_NUM-1:0]                m_aw_ready,
    input  logic [MASTER_NUM-1:0][ID_WIDTH-1:0]  m_aw_id,
    input  logic [MASTER_NUM-1:0][ADDR_WIDTH-1:0] m_aw_addr,
    input  logic [MASTER_NUM-1:0]                m_w_valid,
    output logic [MASTER_NUM-1:0]                m_w_ready,
    input  logic [MASTER_NUM-1:0]                m_w_last,
    input  logic [MASTER_NUM-1:0][DATA_WIDTH-1:0] m_w_data,
    input  logic [MASTER_NUM-1:0][SW-1:0]        m_w_strb,
    output logic [MASTER_NUM-1:0]                m_b_valid,
    input  logic [MASTER_NUM-1:0]                m_b_ready,
    output logic [ID_WIDTH-1:0]                  m_b_id,
    output logic [1:0]                           m_b_resp,
    output logic                                 s_aw_valid,
    input  logic                                 s_aw_ready,
    output logic [ID_WIDTH+IW-1:0]               s_aw_id,
    output logic [ADDR_WIDTH-1:0]                s_aw_addr,
    output logic                                 s_w_valid,
    input  logic                                 s_w_ready,
    output logic                                 s_w_last,
    output logic [DATA_WIDTH-1:0]                s_w_data,
    output logic [SW-1:0]                        s_w_strb,
    input  logic                                 s_b_valid,
    output logic                                 s_b_ready,
    input  logic [ID_WIDTH+IW-1:0]               s_b_id,
    input  logic [1:0]                           s_b_resp
);
    localparam int PW = $clog2(FIFO_DEPTH);

    logic                   aw_vld;
    logic [ID_WIDTH+IW-1:0] aw_id;
    logic [ADDR_WIDTH-1:0]  aw_addr;
    logic [IW-1:0]          rr, win, head, b_idx;
    logic                   found, load, empty, full, pop, b_hit;
    logic [PW:0]            cnt;
    logic [PW-1:0]          wp, rp;
    logic [IW-1:0]          fifo [FIFO_DEPTH];

    function automatic logic [IW-1:0] wrap(input logic [IW:0] v);
        return (v >= (IW+1)'(MASTER_NUM)) ? IW'(v - (IW+1)'(MASTER_NUM)) : v[IW-1:0];
    endfunction

    // Scan from the farthest offset down so the nearest requester at/after rr wins last.
    always_comb begin
        win   = rr;
        found = 1'b0;
        for (int k = MASTER_NUM - 1; k >= 0; k--) begin
            if (m_aw_valid[wrap({1'b0, rr} + (IW+1)'(k))]) begin
                win   = wrap({1'b0, rr} + (IW+1)'(k));
                found = 1'b1;
            end
        end
    end

    assign empty = (cnt == '0);
    assign full  = (cnt == (PW+1)'(FIFO_DEPTH));
    assign head  = fifo[rp];
    // Gating with rstn keeps every m_aw_ready low for as long as reset is held.
    assign load  = rstn && found && !full && (!aw_vld || s_aw_ready);
    assign pop   = s_w_valid && s_w_ready && s_w_last;

    always_comb begin
        m_aw_ready      = '0;
        m_aw_ready[win] = load;
        m_w_ready       = '0;
        m_w_ready[head] = !empty && s_w_ready;
    end

    assign s_aw_valid = aw_vld;
    assign s_aw_id    = aw_id;
    assign s_aw_addr  = aw_addr;
    assign s_w_valid  = !empty && m_w_valid[head];
    assign s_w_last   = m_w_last[head];
    assign s_w_data   = m_w_data[head];
    assign s_w_strb   = m_w_strb[head];

    // Responses tagged with a nonexistent master index are accepted and dropped.
    assign b_idx     = s_b_id[ID_WIDTH +: IW];
    assign b_hit     = ({1'b0, b_idx} < (IW+1)'(MASTER_NUM));
    assign s_b_ready = b_hit ? m_b_ready[b_idx] : 1'b1;
    assign m_b_id    = s_b_id[ID_WIDTH-1:0];
    assign m_b_resp  = s_b_resp;

    always_comb begin
        m_b_valid = '0;
        if (b_hit) m_b_valid[b_idx] = s_b_valid;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            aw_vld <= 1'b0;
            rr     <= '0;
            cnt    <= '0;
            wp     <= '0;
            rp     <= '0;
        end else begin
            aw_vld <= load || (aw_vld && !s_aw_ready);
            if (load) rr <= wrap({1'b0, win} + (IW+1)'(1));
            if (load) wp <= wp + PW'(1);
            if (pop) rp <= rp + PW'(1);
            cnt <= cnt + (PW+1)'(load) - (PW+1)'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (load) begin
            aw_id    <= {win, m_aw_id[win]};
            aw_addr  <= m_aw_addr[win];
            fifo[wp] <= win;
        end
    end
endmodule

// File: tb/tb_axi_wr_arbiter.sv
// tb_axi_wr_arbiter: scenario tasks plus randomized traffic against a queue-based model
module tb_axi_wr_arbiter;
    localparam int MN = 3, IDW = 4, AW = 32, DW = 32, DEPTH = 4, IW = 2;

    logic clk = 1'b0, rstn = 1'b1;
    logic [MN-1:0] m_aw_valid, m_aw_ready, m_w_valid, m_w_ready, m_w_last, m_b_valid, m_b_ready;
    logic [MN-1:0][IDW-1:0] m_aw_id;
    logic [MN-1:0][AW-1:0] m_aw_addr;
    logic [MN-1:0][DW-1:0] m_w_data;
    logic [MN-1:0][DW/8-1:0] m_w_strb;
    logic [IDW-1:0] m_b_id;
    logic [1:0] m_b_resp, s_b_resp;
    logic s_aw_valid, s_aw_ready, s_w_valid, s_w_ready, s_w_last, s_b_valid, s_b_ready;
    logic [IDW+IW-1:0] s_aw_id, s_b_id;
    logic [AW-1:0] s_aw_addr;
    logic [DW-1:0] s_w_data;
    logic [DW/8-1:0] s_w_strb;
    int checks = 0, errors = 0;

    axi_wr_arbiter #(.MASTER_NUM(MN), .ID_WIDTH(IDW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rstn(rstn),
        .m_aw_valid(m_aw_valid), .m_aw_ready(m_aw_ready), .m_aw_id(m_aw_id), .m_aw_addr(m_aw_addr),
        .m_w_valid(m_w_valid), .m_w_ready(m_w_ready), .m_w_last(m_w_last), .m_w_data(m_w_data), .m_w_strb(m_w_strb),
        .m_b_valid(m_b_valid), .m_b_ready(m_b_ready), .m_b_id(m_b_id), .m_b_resp(m_b_resp),
        .s_aw_valid(s_aw_valid), .s_aw_ready(s_aw_ready), .s_aw_id(s_aw_id), .s_aw_addr(s_aw_addr),
        .s_w_valid(s_w_valid), .s_w_ready(s_w_ready), .s_w_last(s_w_last), .s_w_data(s_w_data), .s_w_strb(s_w_strb),
        .s_b_valid(s_b_valid), .s_b_ready(s_b_ready), .s_b_id(s_b_id), .s_b_resp(s_b_resp)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        m_aw_valid = '0; m_aw_id = '0; m_aw_addr = '0;
        m_w_valid = '0; m_w_last = '0; m_w_data = '0; m_w_strb = '0; m_b_ready = '0;
        s_aw_ready = 1'b1; s_w_ready = 1'b0; s_b_valid = 1'b0; s_b_id = '0; s_b_resp = '0;
    endtask

    task automatic do_reset();
        idle();
        #1 rstn = 1'b0;
        tick();
        tick();
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        idle();
        m_aw_valid = '1; m_w_valid = '1; m_w_last = '1; s_w_ready = 1'b1;
        #2 rstn = 1'b0;
        #1;
        checks++;
        if (m_aw_ready !== 3'b000) begin errors++; $display("FAIL reset_aw_ready got %b exp 000", m_aw_ready); end
        tick();
        tick();
        checks++;
        if ({s_aw_valid, s_w_valid, m_w_ready} !== 5'b0) begin
            errors++; $display("FAIL reset_outputs got aw_v=%b w_v=%b w_rdy=%b exp 0", s_aw_valid, s_w_valid, m_w_ready);
        end
        #1 rstn = 1'b1;
        #1;
        checks++;
        if (m_aw_ready !== 3'b001) begin errors++; $display("FAIL reset_release_ready got %b exp 001", m_aw_ready); end
        tick();
        checks++;
        if ({s_aw_valid, s_aw_id} !== {1'b1, 6'h00}) begin
            errors++; $display("FAIL reset_first_accept got v=%b id=%h exp v=1 id=00", s_aw_valid, s_aw_id);
        end
        idle();
    endtask

    task automatic test_aw_rr();
        do_reset();
        m_aw_id[0] = 4'h5; m_aw_id[1] = 4'hA; m_aw_id[2] = 4'h7;
        m_aw_addr[0] = 32'h1000; m_aw_addr[1] = 32'h2000; m_aw_addr[2] = 32'h3000;
        m_aw_valid = 3'b011;
        #1;
        checks++;
        if (m_aw_ready !== 3'b001) begin errors++; $display("FAIL rr_grant0 got %b exp 001", m_aw_ready); end
        tick();
        m_aw_valid = 3'b010;
        #1;
        checks++;
        if ({s_aw_valid, s_aw_id, s_aw_addr, m_aw_ready} !== {1'b1, 6'h05, 32'h1000, 3'b010}) begin
            errors++; $display("FAIL rr_step1 got v=%b id=%h a=%h rdy=%b exp 1/05/1000/010", s_aw_valid, s_aw_id, s_aw_addr, m_aw_ready);
        end
        tick();
        m_aw_valid = 3'b101;
        #1;
        checks++;
        if ({s_aw_valid, s_aw_id, s_aw_addr, m_aw_ready} !== {1'b1, 6'h1A, 32'h2000, 3'b100}) begin
            errors++; $display("FAIL rr_step2 got v=%b id=%h a=%h rdy=%b exp 1/1a/2000/100", s_aw_valid, s_aw_id, s_aw_addr, m_aw_ready);
        end
        tick();
        #1;
        checks++;
        if ({s_aw_id, s_aw_addr, m_aw_ready} !== {6'h27, 32'h3000, 3'b001}) begin
            errors++; $display("FAIL rr_wrap got id=%h a=%h rdy=%b exp 27/3000/001", s_aw_id, s_aw_addr, m_aw_ready);
        end
        tick();
        m_aw_valid = '0;
        tick();
        checks++;
        if (s_aw_valid !== 1'b0) begin errors++; $display("FAIL rr_drain got %b exp 0", s_aw_valid); end
        idle();
    endtask

    task automatic test_w_order();
        int bc[MN];
        int got = 0;
        logic [MN-1:0] hs;
        logic [DW-1:0] exp_d[8];
        do_reset();
        for (int j = 0; j < 8; j++) exp_d[j] = DW'((j < 4 ? 1 : 0) * 256 + j % 4);
        for (int i = 0; i < MN; i++) bc[i] = (i == 2) ? 4 : 0;
        s_w_ready = 1'b1;
        for (int cyc = 0; cyc < 20 && got < 8; cyc++) begin
            m_aw_valid = (cyc == 0) ? 3'b010 : (cyc == 1) ? 3'b001 : 3'b000;
            for (int i = 0; i < MN; i++) begin
                m_w_valid[i] = bc[i] < 4;
                m_w_data[i]  = DW'(i * 256 + bc[i]);
                m_w_last[i]  = bc[i] == 3;
            end
            #1;
            if (cyc < 2) begin
                checks++;
                if (m_aw_ready !== m_aw_valid) begin errors++; $display("FAIL worder_aw cyc=%0d got %b exp %b", cyc, m_aw_ready, m_aw_valid); end
            end
            if (cyc == 0) begin
                checks++;
                if ({s_w_valid, m_w_ready} !== 4'b0) begin errors++; $display("FAIL worder_same_cycle got v=%b rdy=%b exp 0", s_w_valid, m_w_ready); end
            end
            if (s_w_valid && s_w_ready) begin
                checks++;
                if ({s_w_data, s_w_last} !== {exp_d[got], got % 4 == 3}) begin
                    errors++; $display("FAIL worder_beat%0d got %h/%b exp %h/%b", got, s_w_data, s_w_last, exp_d[got], got % 4 == 3);
                end
                got++;
            end
            hs = m_w_valid & m_w_ready;
            tick();
            for (int i = 0; i < MN; i++) if (hs[i]) bc[i]++;
        end
        checks++;
        if (got !== 8) begin errors++; $display("FAIL worder_count got %0d exp 8", got); end
        idle();
    endtask

    task automatic test_fifo_full();
        int n = 0;
        logic [MN-1:0] e;
        do_reset();
        m_aw_valid = 3'b011;
        for (int cyc = 0; cyc < 8; cyc++) begin
            #1;
            e = (n < DEPTH) ? ((n % 2 == 0) ? 3'b001 : 3'b010) : 3'b000;
            checks++;
            if (m_aw_ready !== e) begin errors++; $display("FAIL full_cyc%0d got %b exp %b", cyc, m_aw_ready, e); end
            if (e != 0) n++;
            tick();
        end
        m_w_valid = 3'b001; m_w_last = 3'b001; s_w_ready = 1'b1;
        #1;
        checks++;
        if ({s_w_valid, m_aw_ready} !== 4'b1000) begin
            errors++; $display("FAIL full_pop_cycle got wv=%b rdy=%b exp 1/000", s_w_valid, m_aw_ready);
        end
        tick();
        m_w_valid = '0; s_w_ready = 1'b0;
        #1;
        checks++;
        if (m_aw_ready !== 3'b001) begin errors++; $display("FAIL full_after_pop got %b exp 001", m_aw_ready); end
        idle();
    endtask

    task automatic test_b_route();
        int idx;
        logic [MN-1:0] ebv;
        logic ebr;
        idle();
        s_b_valid = 1'b1; s_b_id = {2'd1, 4'h3}; s_b_resp = 2'b10; m_b_ready = 3'b010;
        #1;
        checks++;
        if ({m_b_valid, m_b_id, m_b_resp, s_b_ready} !== {3'b010, 4'h3, 2'b10, 1'b1}) begin
            errors++; $display("FAIL b_route got v=%b id=%h r=%b rdy=%b exp 010/3/10/1", m_b_valid, m_b_id, m_b_resp, s_b_ready);
        end
        m_b_ready = 3'b101;
        #1;
        checks++;
        if (s_b_ready !== 1'b0) begin errors++; $display("FAIL b_ready_track got %b exp 0", s_b_ready); end
        s_b_id = {2'd3, 4'h9};
        #1;
        checks++;
        if ({m_b_valid, s_b_ready} !== {3'b000, 1'b1}) begin
            errors++; $display("FAIL b_discard got v=%b rdy=%b exp 000/1", m_b_valid, s_b_ready);
        end
        for (int t = 0; t < 24; t++) begin
            idx = int'($urandom % 4);
            s_b_id = {2'(idx), 4'($urandom)}; s_b_valid = 1'($urandom); s_b_resp = 2'($urandom); m_b_ready = 3'($urandom);
            ebv = (idx < MN && s_b_valid) ? 3'(1 << idx) : 3'b000;
            ebr = (idx < MN) ? m_b_ready[idx] : 1'b1;
            #1;
            checks++;
            if ({m_b_valid, s_b_ready, m_b_id, m_b_resp} !== {ebv, ebr, s_b_id[3:0], s_b_resp}) begin
                errors++; $display("FAIL b_rand%0d got v=%b rdy=%b id=%h exp v=%b rdy=%b id=%h", t, m_b_valid, s_b_ready, m_b_id, ebv, ebr, s_b_id[3:0]);
            end
        end
        idle();
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        m_aw_id[0] = 4'hC;
        m_aw_valid = 3'b001;
        tick();
        m_aw_valid = '0; s_w_ready = 1'b1; m_w_valid = 3'b001; m_w_last = '0; m_w_data[0] = 32'hABCD;
        #1;
        checks++;
        if (s_w_valid !== 1'b1) begin errors++; $display("FAIL midrst_active got %b exp 1", s_w_valid); end
        tick();
        tick();
        m_aw_valid = 3'b011;
        #2 rstn = 1'b0;
        #1;
        checks++;
        if ({s_w_valid, m_w_ready, s_aw_valid, m_aw_ready} !== 8'b0) begin
            errors++; $display("FAIL midrst_clear got wv=%b wr=%b av=%b ar=%b exp 0", s_w_valid, m_w_ready, s_aw_valid, m_aw_ready);
        end
        tick();
        rstn = 1'b1;
        #1;
        checks++;
        if ({s_w_valid, m_aw_ready} !== 4'b0001) begin
            errors++; $display("FAIL midrst_after got wv=%b ar=%b exp 0/001", s_w_valid, m_aw_ready);
        end
        tick();
        checks++;
        if ({s_aw_valid, s_aw_id} !== {1'b1, 6'h0C}) begin
            errors++; $display("FAIL midrst_grant got v=%b id=%h exp 1/0c", s_aw_valid, s_aw_id);
        end
        idle();
    endtask

    task automatic test_random();
        int q[$];
        int rr_m = 0, win, c;
        logic awv = 1'b0;
        logic [IDW+IW-1:0] awid = '0;
        logic [AW-1:0] awaddr = '0;
        logic [MN-1:0] e_ar, e_wr;
        logic e_wv, full;
        do_reset();
        for (int cyc = 0; cyc < 400; cyc++) begin
            m_aw_valid = 3'($urandom); s_aw_ready = ($urandom % 4) != 0;
            m_w_valid = 3'($urandom); m_w_last = 3'($urandom); s_w_ready = ($urandom % 3) != 0;
            for (int i = 0; i < MN; i++) begin
                m_aw_id[i] = 4'($urandom); m_aw_addr[i] = $urandom; m_w_data[i] = $urandom; m_w_strb[i] = 4'($urandom);
            end
            win = -1;
            for (int k = 0; k < MN; k++) begin
                c = (rr_m + k) % MN;
                if (win < 0 && m_aw_valid[c]) win = c;
            end
            full = q.size() == DEPTH;
            e_ar = (win >= 0 && !full && (!awv || s_aw_ready)) ? 3'(1 << win) : 3'b000;
            e_wv = q.size() > 0 && m_w_valid[q[0]];
            e_wr = (q.size() > 0 && s_w_ready) ? 3'(1 << q[0]) : 3'b000;
            #1;
            checks++;
            if ({m_aw_ready, s_aw_valid} !== {e_ar, awv}) begin
                errors++; $display("FAIL rand_aw cyc=%0d got rdy=%b v=%b exp rdy=%b v=%b", cyc, m_aw_ready, s_aw_valid, e_ar, awv);
            end
            if (awv) begin
                checks++;
                if ({s_aw_id, s_aw_addr} !== {awid, awaddr}) begin
                    errors++; $display("FAIL rand_aw_data cyc=%0d got %h/%h exp %h/%h", cyc, s_aw_id, s_aw_addr, awid, awaddr);
                end
            end
            checks++;
            if ({s_w_valid, m_w_ready} !== {e_wv, e_wr}) begin
                errors++; $display("FAIL rand_w cyc=%0d got v=%b rdy=%b exp v=%b rdy=%b", cyc, s_w_valid, m_w_ready, e_wv, e_wr);
            end
            if (q.size() > 0) begin
                checks++;
                if ({s_w_data, s_w_strb, s_w_last} !== {m_w_data[q[0]], m_w_strb[q[0]], m_w_last[q[0]]}) begin
                    errors++; $display("FAIL rand_w_data cyc=%0d got %h exp %h from master %0d", cyc, s_w_data, m_w_data[q[0]], q[0]);
                end
            end
            if (e_wv && s_w_ready && m_w_last[q[0]]) void'(q.pop_front());
            if (e_ar != 0) begin
                q.push_back(win);
                awv = 1'b1; awid = {2'(win), m_aw_id[win]}; awaddr = m_aw_addr[win];
                rr_m = (win + 1) % MN;
            end else if (s_aw_ready) awv = 1'b0;
            tick();
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_aw_rr();
        test_w_order();
        test_fifo_full();
        test_b_route();
        test_reset_mid_burst();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
